// File: rtl/logica_comb_entrada_if.sv
// Pin bundle of the next-state logic: FSM inputs, fed-back state,
// combinational next state and its registered copy.
interface logica_comb_entrada_if;
    logic I;     // external data input
    logic S;     // select: 1 = load I, 0 = hold y
    logic y;     // present state from the state register
    logic Yout;  // combinational next state
    logic Yq;    // Yout registered on clk

    // Driver side: the FSM pins and the state register feedback
    modport master (
        output I,
        output S,
        output y,
        input  Yout,
        input  Yq
    );

    // The next-state block itself
    modport slave (
        input  I,
        input  S,
        input  y,
        output Yout,
        output Yq
    );
endinterface

// File: rtl/logica_comb_entrada.sv
// Next-state (input) logic of the single-bit Mealy FSM.
// Yout is a pure 2:1 mux of I and y selected by S; Yq is Yout
// registered on clk with a synchronous active-low reset.
module logica_comb_entrada #(
    parameter logic RESET_VAL = 1'b0
) (
    input logic                 clk,
    input logic                 rst_n,
    logica_comb_entrada_if.slave bus
);

    logic yout_c;
    logic yq_r;

    // Next state: load I when S is high, otherwise hold the present state.
    // The conditional operator keeps Yout known whenever the selected leg
    // is known, even if the other leg is X.
    always_comb begin
        yout_c = 1'b0;
        yout_c = bus.S ? bus.I : bus.y;
    end

    // Registered copy of the next state; reset only takes effect on an edge
    always_ff @(posedge clk) begin
        if (!rst_n) yq_r <= RESET_VAL;
        else        yq_r <= yout_c;
    end

    assign bus.Yout = yout_c;
    assign bus.Yq   = yq_r;

endmodule

// File: tb/tb_logica_comb_entrada.sv
// Self-checking bench for logica_comb_entrada: truth-table vectors,
// hand-written reset/latency sequences and a randomized run against a
// lookup-based reference model.
module tb_logica_comb_entrada;

    logic clk;
    logic rst_n;

    logica_comb_entrada_if bif ();

    logica_comb_entrada #(.RESET_VAL(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic i;
        logic s;
        logic y;
        logic yout;
    } vec_t;

    vec_t tbl [8];

    int vectors;
    int miscompares;

    // Reference: next state written as the truth table indexed by {I,S,y}
    logic [7:0] ref_tt;
    function automatic logic ref_next(input logic i, input logic s, input logic y);
        int idx;
        idx = i * 4 + s * 2 + y;
        return ref_tt[idx];
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic i, input logic s, input logic y);
        bif.I = i;
        bif.S = s;
        bif.y = y;
    endtask

    initial begin
        logic exp_yq;
        logic [2:0] r;
        logic rs;

        vectors     = 0;
        miscompares = 0;
        // index {I,S,y}: 000..111 -> 0,1,0,0,0,1,1,1
        ref_tt = 8'b1110_0010;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // 1. Exhaustive sweep, one time unit per step
        $monitor("t=%0t I=%b S=%b y=%b Yout=%b", $time, bif.I, bif.S, bif.y, bif.Yout);
        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].i, tbl[k].s, tbl[k].y);
            #1;
            check($sformatf("sweep[%0d]", k), bif.Yout, tbl[k].yout);
        end
        $monitoroff;

        // 2. Hold path, S=0: Yout follows y regardless of I
        for (int n = 0; n < 2; n++) begin
            logic iv;
            logic [2:0] yseq;
            iv   = (n == 0) ? 1'b1 : 1'b0;
            yseq = 3'b010;
            for (int k = 2; k >= 0; k--) begin
                drive(iv, 1'b0, yseq[k]);
                #1;
                check($sformatf("hold I=%b step%0d", iv, 2 - k), bif.Yout, yseq[k]);
            end
        end

        // 3. Load path, S=1, y=1: Yout follows I
        begin
            logic [2:0] iseq;
            iseq = 3'b101;
            for (int k = 2; k >= 0; k--) begin
                drive(iseq[k], 1'b1, 1'b1);
                #1;
                check($sformatf("load step%0d", 2 - k), bif.Yout, iseq[k]);
            end
        end

        // 4. Reset for two edges with I=1,S=1; Yout stays valid meanwhile
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset Yq", bif.Yq, 1'b0);
        check("reset Yout", bif.Yout, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release Yq", bif.Yq, 1'b1);

        // Reset pulse between edges has no effect
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("glitch rst Yq", bif.Yq, 1'b1);

        // 5. Reset mid-operation: Yq holds until the edge, then clears
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst before edge Yq", bif.Yq, 1'b1);
        check("midrst Yout", bif.Yout, 1'b1);
        @(posedge clk);
        #1;
        check("midrst after edge Yq", bif.Yq, 1'b0);
        check("midrst Yout after", bif.Yout, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // 6. Registered latency: S=1, y=0, I stepped 1,0,1
        begin
            logic [2:0] iseq;
            iseq = 3'b101;
            for (int k = 2; k >= 0; k--) begin
                @(negedge clk);
                drive(iseq[k], 1'b1, 1'b0);
                #1;
                check($sformatf("lat Yout step%0d", 2 - k), bif.Yout, iseq[k]);
                check($sformatf("lat Yq pre step%0d", 2 - k), bif.Yq,
                      (k == 2) ? 1'b1 : iseq[k + 1]);
                @(posedge clk);
                #1;
                check($sformatf("lat Yq step%0d", 2 - k), bif.Yq, iseq[k]);
            end
        end

        // Randomized run against the lookup model
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            r  = 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            drive(r[2], r[1], r[0]);
            rst_n = rs;
            #1;
            check($sformatf("rand Yout c%0d", c), bif.Yout, ref_next(r[2], r[1], r[0]));
            exp_yq = rs ? ref_next(r[2], r[1], r[0]) : 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("rand Yq c%0d", c), bif.Yq, exp_yq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, limit reached");
        $fatal(1);
    end

endmodule
